// File: rtl/fifo_pkg.sv
// Pointer helpers shared by the read- and write-domain FIFO controllers.
// The Gray conversions work on any width up to 32 bits because zero upper bits do not change the result.
package fifo_pkg;

   function automatic int ptr_width(input int addr_w);
      return addr_w + 1;
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down, built from doubling shifts.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = g;
      for (int s = 1; s < 32; s = s * 2) begin
         b = b ^ (b >> s);
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the FIFO: storage-array read port plus the valid/ready output stream.
interface fifo_rd_ctrl_if #(
   parameter int SIZE_DATA = 8,
   parameter int SIZE_ADDR = 4
);
   logic                 o_mem_rd_en;
   logic [SIZE_ADDR-1:0] o_mem_addr_rd;
   logic [SIZE_DATA-1:0] i_mem_data_rd;
   logic [SIZE_DATA-1:0] o_data;
   logic                 o_valid;
   logic                 i_ready;

   modport master (
      output o_mem_rd_en, o_mem_addr_rd, o_data, o_valid,
      input  i_mem_data_rd, i_ready
   );

   modport slave (
      input  o_mem_rd_en, o_mem_addr_rd, o_data, o_valid,
      output i_mem_data_rd, i_ready
   );
endinterface

// File: rtl/sync_ptr_gray.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
module sync_ptr_gray #(
   parameter int SIZE_W      = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [SIZE_W-1:0] i_d,
   output logic [SIZE_W-1:0] o_q
);
   logic [SIZE_W-1:0] sync_q [SYNC_STAGES];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= i_d;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign o_q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: write-pointer sync, empty/level flags,
// array read issue and a 2-entry registered output buffer.
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int SIZE_DATA   = 8,
   parameter int SIZE_DEPTH  = 16,
   parameter int SIZE_ADDR   = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic               i_clk_rd,
   input  logic               i_rst_rd_n,
   input  logic [SIZE_ADDR:0] i_wr_ptr_gray,
   output logic [SIZE_ADDR:0] o_rd_ptr_gray,
   output logic               o_empty,
   output logic [SIZE_ADDR:0] o_rd_level,
   fifo_rd_ctrl_if.master     bus
);
   localparam int SIZE_PTR = ptr_width(SIZE_ADDR);
   typedef logic [SIZE_PTR-1:0] ptr_t;

   if (SIZE_DEPTH != (1 << SIZE_ADDR)) begin : g_depth_chk
      $error("SIZE_DEPTH must equal 2**SIZE_ADDR");
   end

   ptr_t                 wq, wr_bin;
   ptr_t                 rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d, level_q;
   logic                 empty_q, pend_q, valid_q;
   logic                 issue, pop, capture;
   logic [1:0]           occ_q, occ_d;
   logic [2:0]           fill_after;
   logic [SIZE_DATA-1:0] head_q, head_d, skid_q, skid_d;

   sync_ptr_gray #(.SIZE_W(SIZE_PTR), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk   (i_clk_rd),
      .i_rst_n (i_rst_rd_n),
      .i_d     (i_wr_ptr_gray),
      .o_q     (wq)
   );

   assign wr_bin  = SIZE_PTR'(gray2bin(32'(wq)));
   assign pop     = valid_q & bus.i_ready;
   assign capture = pend_q;

   // Buffer fill after this cycle; issuing only below 2 leaves room for the read in flight.
   assign fill_after = 3'(occ_q) + 3'(pend_q) - 3'(pop);
   assign issue      = !empty_q && (fill_after < 3'd2);
   assign occ_d      = fill_after[1:0];
   assign rd_bin_d   = rd_bin_q + ptr_t'(issue);
   assign rd_gray_d  = SIZE_PTR'(bin2gray(32'(rd_bin_d)));

   // head_q is always the oldest word; skid_q only holds a second word when occ is 2.
   always_comb begin
      head_d = head_q;
      skid_d = skid_q;
      if (pop) begin
         if (occ_q == 2'd2) head_d = skid_q;
         else if (capture)  head_d = bus.i_mem_data_rd;
      end else if (capture) begin
         if (occ_q == 2'd0) head_d = bus.i_mem_data_rd;
         else               skid_d = bus.i_mem_data_rd;
      end
   end

   always_ff @(posedge i_clk_rd or negedge i_rst_rd_n) begin
      if (!i_rst_rd_n) begin
         rd_bin_q  <= '0;
         rd_gray_q <= '0;
         empty_q   <= 1'b1;
         level_q   <= '0;
         pend_q    <= 1'b0;
         occ_q     <= 2'd0;
         valid_q   <= 1'b0;
         head_q    <= '0;
         skid_q    <= '0;
      end else begin
         rd_bin_q  <= rd_bin_d;
         rd_gray_q <= rd_gray_d;
         empty_q   <= (rd_gray_d == wq);
         level_q   <= wr_bin - rd_bin_d;
         pend_q    <= issue;
         occ_q     <= occ_d;
         valid_q   <= (occ_d != 2'd0);
         head_q    <= head_d;
         skid_q    <= skid_d;
      end
   end

   assign o_rd_ptr_gray     = rd_gray_q;
   assign o_empty           = empty_q;
   assign o_rd_level        = level_q;
   assign bus.o_mem_rd_en   = issue;
   assign bus.o_mem_addr_rd = rd_bin_q[SIZE_ADDR-1:0];
   assign bus.o_data        = head_q;
   assign bus.o_valid       = valid_q;
endmodule
